mem_access_stage: RTL and testbench

- Memory stage of the 5-stage pipeline, directly downstream of the EX/MEM pipe register.
- Takes ALU result/address, store data and destination register; performs byte/half/word loads and stores on a single-outstanding ready/req data-memory bus.
- Drives a registered result toward MEM/WB and a stall back to the earlier stages while an access is pending.
- Non-memory instructions pass through with 1-cycle latency.

---
 rtl/mem_access_stage_if.sv | 23 ++
 rtl/mem_access_stage.sv | 171 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Single-outstanding data-memory bus between the MEM stage (master) and data memory (slave).
// mem_rdata is only meaningful in a cycle where mem_ready is high.
interface mem_access_stage_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: byte/half/word loads and stores over a single-outstanding bus,
// registered result toward MEM/WB and a combinational stall while an access is pending.
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [31:0]        data_1_in,
    input  logic [31:0]        data_2_in,
    input  logic [4:0]         rd_in,
    input  logic               reg_write_in,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [1:0]         mem_size,
    input  logic               load_signed,
    output logic               stall,
    mem_access_stage_if.master bus,
    output logic [31:0]        result_out,
    output logic [4:0]         rd_out,
    output logic               reg_write_out,
    output logic               out_valid,
    output logic               misalign_err,
    output logic               bus_err
);
    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       addr_lo;
    logic [1:0]       size_q;
    logic             sign_q;
    logic             store_q;
    logic             rw_q;
    logic [4:0]       rd_q;

    logic mem_op;
    logic aligned;
    logic timeout;

    function automatic logic [31:0] store_data(input logic [31:0] d, input logic [1:0] size);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] lo, input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] lo,
                                                 input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{lo, 3'b000} +: 8];
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   return sgn ? {{24{b[7]}}, b} : {24'b0, b};
            2'b01:   return sgn ? {{16{h[15]}}, h} : {16'b0, h};
            default: return rdata;
        endcase
    endfunction

    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        mem_op  = in_valid & (mem_read | mem_write);
        aligned = 1'b1;
        case (mem_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~data_1_in[0];
            default: aligned = (data_1_in[1:0] == 2'b00);
        endcase
        timeout = (cnt == CNT_LAST) & ~bus.mem_ready;
        stall   = 1'b0;
        // Held in reset the stage is idle, so the stall must drop with it.
        if (rst) begin
            if (state == IDLE) stall = mem_op & aligned;
            else               stall = ~bus.mem_ready & ~timeout;
        end
    end

    // NOTE: state and registered outputs use non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            addr_lo       <= '0;
            size_q        <= '0;
            sign_q        <= 1'b0;
            store_q       <= 1'b0;
            rw_q          <= 1'b0;
            rd_q          <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
            result_out    <= '0;
            rd_out        <= '0;
            reg_write_out <= 1'b0;
            out_valid     <= 1'b0;
            misalign_err  <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            out_valid    <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && !mem_op) begin
                        out_valid     <= 1'b1;
                        result_out    <= data_1_in;
                        rd_out        <= rd_in;
                        reg_write_out <= reg_write_in;
                    end else if (mem_op && !aligned) begin
                        out_valid     <= 1'b1;
                        misalign_err  <= 1'b1;
                        result_out    <= '0;
                        rd_out        <= rd_in;
                        reg_write_out <= 1'b0;
                    end else if (mem_op) begin
                        state         <= ACCESS;
                        cnt           <= '0;
                        addr_lo       <= data_1_in[1:0];
                        size_q        <= mem_size;
                        sign_q        <= load_signed;
                        store_q       <= mem_write;
                        rw_q          <= reg_write_in;
                        rd_q          <= rd_in;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= mem_write;
                        bus.mem_addr  <= {data_1_in[ADDR_W-1:2], 2'b00};
                        bus.mem_wdata <= store_data(data_2_in, mem_size);
                        bus.mem_be    <= byte_en(data_1_in[1:0], mem_size);
                    end
                end
                ACCESS: begin
                    if (bus.mem_ready || timeout) begin
                        state       <= IDLE;
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        bus.mem_be  <= '0;
                        out_valid   <= 1'b1;
                        bus_err     <= ~bus.mem_ready;
                        rd_out      <= rd_q;
                        if (bus.mem_ready && !store_q) begin
                            result_out    <= load_extract(bus.mem_rdata, addr_lo, size_q, sign_q);
                            reg_write_out <= rw_q;
                        end else begin
                            result_out    <= '0;
                            reg_write_out <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised scoreboard bench for mem_access_stage: a byte-level memory model predicts every
// result, a bus responder checks each request and a monitor compares every out_valid pulse.
module tb_mem_access_stage;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic        rw;
        logic        ld;
        logic        st;
        logic [1:0]  size;
        logic        sgn;
    } instr_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        rw;
        logic        mis;
        logic        berr;
        logic        chk_rd;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] data_1_in;
    logic [31:0] data_2_in;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        load_signed;
    logic        stall;
    logic [31:0] result_out;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic        out_valid;
    logic        misalign_err;
    logic        bus_err;

    mem_access_stage_if #(.ADDR_W(32)) bus ();

    mem_access_stage #(.TIMEOUT(TIMEOUT), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .data_1_in    (data_1_in),
        .data_2_in    (data_2_in),
        .rd_in        (rd_in),
        .reg_write_in (reg_write_in),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_size     (mem_size),
        .load_signed  (load_signed),
        .stall        (stall),
        .bus          (bus),
        .result_out   (result_out),
        .rd_out       (rd_out),
        .reg_write_out(reg_write_out),
        .out_valid    (out_valid),
        .misalign_err (misalign_err),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     rise_cyc = 0;
    logic   prev_req = 1'b0;
    bit     manual = 1'b0;
    exp_t   exp_q[$];
    bus_t   bus_q[$];
    int     wait_q[$];
    logic [31:0] ref_mem [16];
    logic [31:0] bus_mem [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: spec rules applied to a byte-addressed view of memory.
    function automatic void model(input instr_t ins, input int wt, output exp_t e,
                                  output bus_t b, output bit go);
        int          nbytes;
        int          off;
        int          idx;
        logic [31:0] w;
        logic [31:0] mask;
        logic [31:0] val;
        e  = '0;
        b  = '0;
        go = 1'b0;
        if (!(ins.ld || ins.st)) begin
            e.result = ins.d1;
            e.rd     = ins.rd;
            e.rw     = ins.rw;
            e.chk_rd = 1'b1;
            return;
        end
        nbytes = (ins.size == 2'd0) ? 1 : (ins.size == 2'd1) ? 2 : 4;
        if ((ins.d1 % nbytes) != 0) begin
            e.mis = 1'b1;
            return;
        end
        go      = 1'b1;
        off     = int'(ins.d1 % 4);
        idx     = int'((ins.d1 / 4) % 16);
        b.addr  = ins.d1 - ins.d1 % 4;
        b.we    = ins.st;
        for (int i = 0; i < nbytes; i++) b.be[off + i] = 1'b1;
        b.wdata = (nbytes == 1) ? {4{ins.d2[7:0]}} : (nbytes == 2) ? {2{ins.d2[15:0]}} : ins.d2;
        if (wt >= TIMEOUT) begin
            e.berr = 1'b1;
            return;
        end
        if (ins.st) begin
            for (int i = 0; i < nbytes; i++) ref_mem[idx][8*(off+i) +: 8] = ins.d2[8*i +: 8];
            return;
        end
        w    = ref_mem[idx] >> (8 * off);
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nbytes)) - 32'h1;
        val  = w & mask;
        if (ins.sgn && nbytes < 4 && val[8*nbytes-1]) val = val | ~mask;
        e.result = val;
        e.rd     = ins.rd;
        e.rw     = ins.rw;
        e.chk_rd = 1'b1;
    endfunction

    function automatic instr_t mk(input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] rd,
                                  input logic rw, input logic ld, input logic st,
                                  input logic [1:0] size, input logic sgn);
        instr_t i;
        i = '{d1: d1, d2: d2, rd: rd, rw: rw, ld: ld, st: st, size: size, sgn: sgn};
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        int     k;
        k      = $urandom_range(0, 3);
        i.ld   = (k == 1 || k == 3);
        i.st   = (k == 2 || k == 3);
        i.size = 2'($urandom_range(0, 3));
        i.sgn  = 1'($urandom_range(0, 1));
        i.d2   = $urandom;
        i.rd   = 5'($urandom);
        i.rw   = 1'($urandom_range(0, 1));
        i.d1   = (k == 0) ? $urandom : 32'h100 + 32'($urandom_range(0, 63));
        return i;
    endfunction

    // Present one instruction at a negedge and hold it, like EX/MEM, until stall lets it go.
    task automatic issue(input instr_t ins, input int wt);
        exp_t e;
        bus_t b;
        bit   go;
        bit   st;
        int   stall_cycles;
        int   n;
        model(ins, wt, e, b, go);
        exp_q.push_back(e);
        if (go) begin
            wait_q.push_back(wt);
            bus_q.push_back(b);
        end
        in_valid     = 1'b1;
        data_1_in    = ins.d1;
        data_2_in    = ins.d2;
        rd_in        = ins.rd;
        reg_write_in = ins.rw;
        mem_read     = ins.ld;
        mem_write    = ins.st;
        mem_size     = ins.size;
        load_signed  = ins.sgn;
        stall_cycles = 0;
        n            = 0;
        forever begin
            #2;
            st = stall;
            if (st) stall_cycles++;
            @(negedge clk);
            if (!st) break;
            n++;
            if (n > TIMEOUT + 8) begin
                check("accept_bound", 32'd1, 32'd0);
                break;
            end
        end
        check("stall_cycles", stall_cycles, !go ? 0 : e.berr ? TIMEOUT : 1 + wt);
        if (!go) check("no_req", bus.mem_req, 1'b0);
        in_valid  = 1'b0;
        data_1_in = $urandom;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.mem_req && !prev_req) rise_cyc = cyc;
            prev_req = bus.mem_req;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result_out", result_out, e.result);
                    check("reg_write_out", reg_write_out, e.rw);
                    check("misalign_err", misalign_err, e.mis);
                    check("bus_err", bus_err, e.berr);
                    if (e.chk_rd) check("rd_out", rd_out, e.rd);
                    if (e.berr) begin
                        check("bus_err_gap", cyc - rise_cyc, TIMEOUT);
                        check("bus_err_req_low", bus.mem_req, 1'b0);
                    end
                end
            end else if (misalign_err || bus_err) begin
                check("err_without_valid", {misalign_err, bus_err}, 32'd0);
            end
        end
    end

    initial begin : responder
        bit   busy;
        int   cnt;
        int   wt;
        bus_t cur;
        busy = 1'b0;
        cnt  = 0;
        wt   = 0;
        cur  = '0;
        forever begin
            @(negedge clk);
            if (manual) begin
                busy = 1'b0;
                continue;
            end
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
            if (!bus.mem_req) begin
                busy = 1'b0;
                continue;
            end
            if (!busy) begin
                busy = 1'b1;
                cnt  = 0;
                if (wait_q.size() == 0 || bus_q.size() == 0) begin
                    check("spurious_req", 32'd1, 32'd0);
                    wt  = 0;
                    cur = '{addr: bus.mem_addr, we: bus.mem_we, be: bus.mem_be, wdata: bus.mem_wdata};
                end else begin
                    wt  = wait_q.pop_front();
                    cur = bus_q.pop_front();
                end
            end
            check("mem_addr", bus.mem_addr, cur.addr);
            check("mem_we", bus.mem_we, cur.we);
            check("mem_be", bus.mem_be, cur.be);
            if (cur.we) check("mem_wdata", bus.mem_wdata, cur.wdata);
            if (cnt == wt) begin
                bus.mem_ready = 1'b1;
                if (bus.mem_we) begin
                    for (int i = 0; i < 4; i++)
                        if (bus.mem_be[i]) bus_mem[bus.mem_addr[5:2]][8*i +: 8] = bus.mem_wdata[8*i +: 8];
                end else begin
                    bus.mem_rdata = bus_mem[bus.mem_addr[5:2]];
                end
                busy = 1'b0;
            end else begin
                cnt++;
            end
        end
    end

    initial begin : stimulus
        int wt;
        int r;
        rst           = 1'b0;
        in_valid      = 1'b0;
        data_1_in     = '0;
        data_2_in     = '0;
        rd_in         = '0;
        reg_write_in  = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_size      = '0;
        load_signed   = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            bus_mem[i] = ref_mem[i];
        end

        repeat (2) @(negedge clk);
        check("rst_stall", stall, 1'b0);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result_out", result_out, 32'd0);
        check("rst_rd_out", rd_out, 5'd0);
        check("rst_reg_write_out", reg_write_out, 1'b0);
        check("rst_errs", {misalign_err, bus_err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        issue(mk(32'h0000_1234, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0), 0);
        ref_mem[0] = 32'h80AB_CDEF;
        bus_mem[0] = 32'h80AB_CDEF;
        issue(mk(32'h0000_0103, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1), 3);
        issue(mk(32'h0000_0202, 32'hAAAA_BEEF, 5'd4, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0), 1);
        issue(mk(32'h0000_0101, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0), 0);
        issue(mk(32'h0000_0104, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0), NEVER);
        issue(mk(32'h5555_0001, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0), 0);
        issue(mk(32'h0000_0108, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0), TIMEOUT - 1);
        issue(mk(32'h0000_0100, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0), 0);
        issue(mk(32'h0000_0102, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1), 2);
        repeat (2) @(negedge clk);

        // Reset in the middle of an access, then a late ready that must be ignored.
        manual        = 1'b1;
        bus.mem_ready = 1'b0;
        in_valid      = 1'b1;
        data_1_in     = 32'h0000_010C;
        mem_read      = 1'b1;
        mem_write     = 1'b0;
        mem_size      = 2'd2;
        @(negedge clk);
        check("mid_access_req", bus.mem_req, 1'b1);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_mem_req", bus.mem_req, 1'b0);
        check("mid_rst_stall", stall, 1'b0);
        check("mid_rst_out_valid", out_valid, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            check("late_ready_out_valid", out_valid, 1'b0);
            check("late_ready_mem_req", bus.mem_req, 1'b0);
        end
        manual = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 250; n++) begin
            r  = $urandom_range(0, 15);
            wt = (r == 0) ? NEVER : (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 4);
            issue(rand_instr(), wt);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        for (int i = 0; i < 4 * TIMEOUT && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_exp_q", exp_q.size(), 32'd0);
        check("drain_wait_q", wait_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
